// File: rtl/uart_frame_parser_if.sv
// Byte-stream input and payload-stream output of the UART frame parser.
// master is the parser side, slave is the UART receiver plus payload sink.
interface uart_frame_parser_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] pld_data;
    logic       pld_valid;
    logic       pld_ready;
    logic       pld_last;
    logic       frame_ok;
    logic       err;
    logic [1:0] err_code;
    logic       rx_drop;

    modport master (
        input  rx_byte, rx_valid, pld_ready,
        output pld_data, pld_valid, pld_last, frame_ok, err, err_code, rx_drop
    );

    modport slave (
        output rx_byte, rx_valid, pld_ready,
        input  pld_data, pld_valid, pld_last, frame_ok, err, err_code, rx_drop
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CHK frames from a UART byte stream and releases the
// buffered payload over valid/ready only after the checksum verifies.
module uart_frame_parser #(
    parameter logic [7:0]  SOF          = 8'hAA,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 104166
) (
    input logic                 clk,
    input logic                 rst,
    uart_frame_parser_if.master bus
);
    localparam int unsigned     IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned     TMO_W     = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 2);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_SEND
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] len_m1_q;
    logic [7:0]       sum_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [TMO_W-1:0] tmo_q;
    logic [7:0]       mem_q [MAX_LEN];

    logic [7:0]       pld_data_q;
    logic             pld_valid_q;
    logic             pld_last_q;
    logic             frame_ok_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic             rx_drop_q;

    logic             in_frame;
    logic             tmo_expired;
    logic             len_bad;
    logic             rd_last;
    logic [IDX_W-1:0] rd_nxt;

    always_comb begin
        in_frame    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
        // The counter only reaches TMO_LAST-level expiry when no byte arrives this cycle.
        tmo_expired = in_frame && !bus.rx_valid && (tmo_q == TMO_LAST);
        len_bad     = (bus.rx_byte == 8'd0) || (bus.rx_byte > MAX_LEN_B);
        rd_last     = (rd_idx_q == len_m1_q);
        rd_nxt      = rd_idx_q + 1'b1;
    end

    // Payload storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if ((state_q == S_DATA) && bus.rx_valid) begin
            mem_q[wr_idx_q] <= bus.rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_m1_q    <= '0;
            sum_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            tmo_q       <= '0;
            pld_data_q  <= '0;
            pld_valid_q <= 1'b0;
            pld_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            rx_drop_q   <= 1'b0;
        end else begin
            frame_ok_q <= 1'b0;
            err_q      <= 1'b0;
            rx_drop_q  <= 1'b0;
            tmo_q      <= (in_frame && !bus.rx_valid) ? tmo_q + 1'b1 : '0;

            if (tmo_expired) begin
                state_q    <= S_IDLE;
                tmo_q      <= '0;
                err_q      <= 1'b1;
                err_code_q <= 2'b11;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.rx_valid && (bus.rx_byte == SOF)) begin
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (bus.rx_valid) begin
                            if (len_bad) begin
                                state_q    <= S_IDLE;
                                err_q      <= 1'b1;
                                err_code_q <= 2'b01;
                            end else begin
                                len_m1_q <= IDX_W'(bus.rx_byte - 8'd1);
                                sum_q    <= bus.rx_byte;
                                wr_idx_q <= '0;
                                state_q  <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (bus.rx_valid) begin
                            sum_q    <= sum_q + bus.rx_byte;
                            wr_idx_q <= wr_idx_q + 1'b1;
                            if (wr_idx_q == len_m1_q) begin
                                state_q <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_byte == sum_q) begin
                                state_q     <= S_SEND;
                                rd_idx_q    <= '0;
                                pld_valid_q <= 1'b1;
                                pld_data_q  <= mem_q[0];
                                pld_last_q  <= (len_m1_q == '0);
                                frame_ok_q  <= 1'b1;
                            end else begin
                                state_q    <= S_IDLE;
                                err_q      <= 1'b1;
                                err_code_q <= 2'b10;
                            end
                        end
                    end
                    S_SEND: begin
                        if (bus.rx_valid) begin
                            rx_drop_q <= 1'b1;
                        end
                        if (bus.pld_ready) begin
                            if (rd_last) begin
                                state_q     <= S_IDLE;
                                pld_valid_q <= 1'b0;
                                pld_last_q  <= 1'b0;
                            end else begin
                                rd_idx_q   <= rd_nxt;
                                pld_data_q <= mem_q[rd_nxt];
                                pld_last_q <= (rd_nxt == len_m1_q);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.pld_data  = pld_data_q;
    assign bus.pld_valid = pld_valid_q;
    assign bus.pld_last  = pld_last_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.rx_drop   = rx_drop_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed plus randomized frame stimulus for uart_frame_parser, checked
// against a frame-level reference (expected payload, outcome and timing).
module tb_uart_frame_parser;
    localparam int T    = 40;
    localparam int MAXL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_frame_parser_if bus();

    uart_frame_parser #(
        .SOF(8'hAA),
        .MAX_LEN(MAXL),
        .TIMEOUT_CLKS(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q[$];
    logic       last_q[$];
    int         hs_cyc_q[$];
    logic [1:0] err_q[$];
    int         err_cyc_q[$];
    int         ok_cnt, ok_cyc, drop_cnt;
    logic [7:0] pay[$];
    logic [1:0] held_code;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pld_valid && bus.pld_ready) begin
                got_q.push_back(bus.pld_data);
                last_q.push_back(bus.pld_last);
                hs_cyc_q.push_back(cyc);
            end
            if (bus.frame_ok) begin
                ok_cnt++;
                ok_cyc = cyc;
            end
            if (bus.err) begin
                err_q.push_back(bus.err_code);
                err_cyc_q.push_back(cyc);
            end
            if (bus.rx_drop) drop_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        got_q.delete(); last_q.delete(); hs_cyc_q.delete();
        err_q.delete(); err_cyc_q.delete();
        ok_cnt = 0; ok_cyc = -1; drop_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    function automatic int gap();
        return int'($urandom_range(0, 3));
    endfunction

    task automatic build(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [7:0] chk_of(input int len);
        logic [7:0] s;
        s = 8'(len);
        foreach (pay[i]) s = s + pay[i];
        return s;
    endfunction

    task automatic zero_outputs(input string tag);
        check(tag, {bus.pld_data, bus.pld_valid, bus.pld_last, bus.frame_ok,
                    bus.err, bus.err_code, bus.rx_drop}, 32'd0);
    endtask

    task automatic wait_done(input int nbytes, input bit exp_err, input bit rnd_rdy);
        int n;
        n = 0;
        while (n < 600 && !(exp_err ? (err_q.size() > 0) : (got_q.size() >= nbytes))) begin
            if (rnd_rdy) bus.pld_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.pld_ready = 1'b1;
        idle(3);
        check("wait_in_budget", 32'(n < 600), 32'd1);
    endtask

    task automatic check_good(input string tag, input int sc, input bit strict);
        check({tag, ".nerr"}, err_q.size(), 0);
        check({tag, ".nok"}, ok_cnt, 1);
        check({tag, ".ok_cyc"}, ok_cyc, sc);
        check({tag, ".nbytes"}, got_q.size(), pay.size());
        if (got_q.size() == pay.size()) begin
            foreach (pay[i]) begin
                check($sformatf("%s.data%0d", tag, i), got_q[i], pay[i]);
                check($sformatf("%s.last%0d", tag, i), last_q[i], (i == pay.size() - 1));
                if (strict) check($sformatf("%s.hs_cyc%0d", tag, i), hs_cyc_q[i], sc + i);
            end
        end
    endtask

    task automatic run_frame(input int len, input logic [7:0] adj, input bit rnd_rdy, input string tag);
        bit lenbad;
        logic [7:0] c;
        int sc;
        lenbad = (len == 0) || (len > MAXL);
        c = chk_of(len) + adj;
        clr();
        bus.pld_ready = 1'b1;
        send(8'hAA);
        idle(gap());
        send(8'(len));
        sc = cyc;
        if (!lenbad) begin
            foreach (pay[i]) begin
                idle(gap());
                send(pay[i]);
            end
            idle(gap());
            send(c);
            sc = cyc;
        end
        wait_done(pay.size(), lenbad || (adj != 8'd0), rnd_rdy);
        if (lenbad || (adj != 8'd0)) begin
            held_code = lenbad ? 2'b01 : 2'b10;
            check({tag, ".nerr"}, err_q.size(), 1);
            if (err_q.size() == 1) begin
                check({tag, ".code"}, err_q[0], held_code);
                check({tag, ".err_cyc"}, err_cyc_q[0], sc);
            end
            check({tag, ".nok"}, ok_cnt, 0);
            check({tag, ".nout"}, got_q.size(), 0);
        end else begin
            check_good(tag, sc, !rnd_rdy);
        end
        check({tag, ".code_held"}, bus.err_code, held_code);
    endtask

    initial begin
        int t0, sc, len;
        logic [7:0] c, adj;
        bus.rx_byte = '0;
        bus.rx_valid = 1'b0;
        bus.pld_ready = 1'b1;
        held_code = 2'b00;
        clr();
        repeat (3) @(posedge clk);
        #1;
        zero_outputs("reset_state");
        rst = 1'b0;
        idle(2);

        pay = '{8'h11, 8'h22, 8'h33};
        run_frame(3, 8'h00, 1'b0, "t1_good");
        run_frame(3, 8'hFF, 1'b0, "t2_badchk");
        run_frame(3, 8'h00, 1'b0, "t2_recover");

        pay.delete();
        run_frame(0, 8'h00, 1'b0, "t3_len0");
        run_frame(17, 8'h00, 1'b0, "t3_len17");
        send(8'h55);
        build(1);
        run_frame(1, 8'h00, 1'b0, "t3_stray_len1");
        build(MAXL);
        run_frame(MAXL, 8'h00, 1'b0, "t3_lenmax");

        // Timeout: expiry exactly T-1 clocks after the last strobe.
        clr();
        send(8'hAA); send(8'h02); send(8'h11);
        t0 = cyc;
        for (int n = 0; n < T + 10 && err_q.size() == 0; n++) tick();
        held_code = 2'b11;
        check("tmo.nerr", err_q.size(), 1);
        if (err_q.size() == 1) begin
            check("tmo.code", err_q[0], 2'b11);
            check("tmo.cycle", err_cyc_q[0], t0 + T - 1);
        end
        idle(2);

        // Strobes landing exactly on the expiry cycle keep the frame alive.
        clr();
        pay = '{8'h11, 8'h22};
        send(8'hAA); send(8'h02); send(8'h11);
        idle(T - 2); send(8'h22);
        idle(T - 2); send(chk_of(2));
        sc = cyc;
        wait_done(2, 1'b0, 1'b0);
        check_good("tmo_alive", sc, 1'b1);

        // Stall: pld_ready low 5 cycles per byte; SOF during SEND is dropped.
        build(4);
        c = chk_of(4);
        clr();
        send(8'hAA); send(8'h04);
        foreach (pay[i]) send(pay[i]);
        bus.pld_ready = 1'b0;
        send(c);
        sc = cyc;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 5; s++) begin
                check($sformatf("stall.valid%0d_%0d", i, s), bus.pld_valid, 1'b1);
                check($sformatf("stall.data%0d_%0d", i, s), bus.pld_data, pay[i]);
                check($sformatf("stall.last%0d_%0d", i, s), bus.pld_last, (i == 3));
                if (i == 1 && s == 2) send(8'hAA);
                else tick();
            end
            bus.pld_ready = 1'b1;
            tick();
            bus.pld_ready = 1'b0;
        end
        bus.pld_ready = 1'b1;
        idle(2);
        check("stall.valid_after", bus.pld_valid, 1'b0);
        check("stall.drop", drop_cnt, 1);
        check_good("stall", sc, 1'b0);
        send(8'h01); send(8'h05); send(8'h06);
        idle(5);
        check("stall.no_new_frame_ok", ok_cnt, 1);
        check("stall.no_new_bytes", got_q.size(), 4);

        // Reset during DATA.
        build(4);
        clr();
        send(8'hAA); send(8'h04); send(pay[0]); send(pay[1]);
        rst = 1'b1;
        #1;
        zero_outputs("rst_data.zero");
        held_code = 2'b00;
        tick();
        rst = 1'b0;
        idle(2);
        check("rst_data.nerr", err_q.size(), 0);
        build(5);
        run_frame(5, 8'h00, 1'b0, "rst_data.next");

        // Reset during SEND.
        build(3);
        c = chk_of(3);
        clr();
        bus.pld_ready = 1'b0;
        send(8'hAA); send(8'h03);
        foreach (pay[i]) send(pay[i]);
        send(c);
        idle(2);
        check("rst_send.valid_before", bus.pld_valid, 1'b1);
        rst = 1'b1;
        #1;
        zero_outputs("rst_send.zero");
        tick();
        rst = 1'b0;
        bus.pld_ready = 1'b1;
        clr();
        idle(5);
        check("rst_send.no_bytes", got_q.size(), 0);
        check("rst_send.nerr", err_q.size(), 0);
        build(2);
        run_frame(2, 8'h00, 1'b0, "rst_send.next");

        // Randomized frames with random lengths, corruption and back-pressure.
        for (int k = 0; k < 20; k++) begin
            len = int'($urandom_range(0, MAXL + 3));
            build((len >= 1 && len <= MAXL) ? len : 0);
            adj = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame(len, adj, 1'b1, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
